// File: rtl/vault_pkg.sv
// Shared vault definitions: door-actuator state encodings and the 1 ms tick divisor.
package vault_pkg;

   typedef enum logic [2:0] {
      ST_LOCKED    = 3'd0,
      ST_RETRACT   = 3'd1,
      ST_UNLOCKED  = 3'd2,
      ST_DOOR_OPEN = 3'd3,
      ST_EXTEND    = 3'd4,
      ST_FAULT     = 3'd5
   } vault_state_t;

   localparam int MS_PER_S = 1000;

   // Clocks per 1 ms tick; never below 1 so slow simulation clocks tick every cycle.
   function automatic int ms_tick_div(input int clk_hz);
      int div;
      div = clk_hz / MS_PER_S;
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/vault_debounce.sv
// Two-flop synchroniser followed by a stable-count filter clocked by a tick strobe.
module vault_debounce #(
   parameter int   STABLE_TICKS = 20,
   parameter logic RST_VAL      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic stable
);

   logic        sync_p0;
   logic        sync_p1;
   logic [31:0] cnt;

   // Any sample matching the accepted value restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= RST_VAL;
         sync_p1 <= RST_VAL;
         stable  <= RST_VAL;
         cnt     <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         if (sync_p1 == stable) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt >= 32'(STABLE_TICKS - 1)) begin
               stable <= sync_p1;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 32'd1;
            end
         end
      end
   end

endmodule

// File: rtl/vault_door_actuator.sv
// Vault door bolt actuator: drives the bolt motor, supervises limit switches and door sensor.
// Optional door-ajar alarm enabled by defining VAULT_DOOR_AJAR_ALARM_EN.
module vault_door_actuator
   import vault_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int DEBOUNCE_MS     = 20,
   parameter int BOLT_TIMEOUT_MS = 2000,
   parameter int RELOCK_MS       = 10000,
   parameter int AJAR_MS         = 60000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       unlock,
   input  logic       bolt_in,
   input  logic       bolt_out,
   input  logic       door_closed,
   input  logic       ack_fault,
   output logic       motor_retract,
   output logic       motor_extend,
   output logic       alarm,
   output logic       fault,
   output logic [2:0] state_led
);

   localparam int TICK_DIV = ms_tick_div(CLK_HZ);

   vault_state_t state, next_state;
   logic [31:0]  tick_cnt;
   logic         tick;
   logic [31:0]  timer;
   logic [32:0]  elapsed;
   logic         bin_p0, bin_p1, bout_p0, bout_p1;
   logic         ack_p0, ack_p1, ack_p2;
   logic         ack_rise;
   logic         door_ok;
   logic         alarm_set, alarm_clr;

   function automatic logic expired(input logic [32:0] el, input int limit);
      return el >= 33'(limit);
   endfunction

   // 1 ms tick strobe
   assign tick = (tick_cnt == 32'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tick_cnt <= '0;
      else     tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
   end

   // Input synchronisers; ack uses a third flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_p0  <= 1'b0;
         bin_p1  <= 1'b0;
         bout_p0 <= 1'b0;
         bout_p1 <= 1'b0;
         ack_p0  <= 1'b0;
         ack_p1  <= 1'b0;
         ack_p2  <= 1'b0;
      end else begin
         bin_p0  <= bolt_in;
         bin_p1  <= bin_p0;
         bout_p0 <= bolt_out;
         bout_p1 <= bout_p0;
         ack_p0  <= ack_fault;
         ack_p1  <= ack_p0;
         ack_p2  <= ack_p1;
      end
   end

   assign ack_rise = ack_p1 & ~ack_p2;

   vault_debounce #(
      .STABLE_TICKS (DEBOUNCE_MS),
      .RST_VAL      (1'b1)
   ) u_door_debounce (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .raw    (door_closed),
      .stable (door_ok)
   );

   // Ticks elapsed in the current state, including the tick of this cycle.
   assign elapsed = {1'b0, timer} + {32'd0, tick};

   always_comb begin
      next_state = state;
      alarm_set  = 1'b0;
      case (state)
         ST_LOCKED: begin
            if (!door_ok)    alarm_set  = 1'b1;
            else if (unlock) next_state = ST_RETRACT;
         end
         ST_RETRACT: begin
            if (bin_p1)                                next_state = ST_UNLOCKED;
            else if (expired(elapsed, BOLT_TIMEOUT_MS)) next_state = ST_FAULT;
         end
         ST_UNLOCKED: begin
            if (!door_ok)                                   next_state = ST_DOOR_OPEN;
            else if (!unlock || expired(elapsed, RELOCK_MS)) next_state = ST_EXTEND;
         end
         ST_DOOR_OPEN: begin
            if (door_ok) next_state = ST_EXTEND;
`ifdef VAULT_DOOR_AJAR_ALARM_EN
            if (expired(elapsed, AJAR_MS)) alarm_set = 1'b1;
`endif
         end
         ST_EXTEND: begin
            if (bout_p1)                                next_state = ST_LOCKED;
            else if (!door_ok)                          next_state = ST_DOOR_OPEN;
            else if (expired(elapsed, BOLT_TIMEOUT_MS)) next_state = ST_FAULT;
         end
         ST_FAULT: begin
            if (ack_rise) next_state = bout_p1 ? ST_LOCKED : ST_EXTEND;
         end
         default: next_state = ST_FAULT;
      endcase
      // Both limit switches at once means a broken switch or a jammed bolt.
      if (state != ST_FAULT && bin_p1 && bout_p1) next_state = ST_FAULT;
   end

   assign alarm_clr = ack_rise && door_ok && (state == ST_LOCKED || state == ST_FAULT);

`ifndef VAULT_DOOR_AJAR_ALARM_EN
   // AJAR_MS has no role without the ajar alarm.
   logic unused_ajar;
   assign unused_ajar = ^32'(AJAR_MS);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_LOCKED;
      else     state <= next_state;
   end

   // Motors follow next_state so drive is registered yet aligned with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer         <= '0;
         motor_retract <= 1'b0;
         motor_extend  <= 1'b0;
         alarm         <= 1'b0;
      end else begin
         if (next_state != state)      timer <= '0;
         else if (tick && timer != '1) timer <= timer + 32'd1;
         motor_retract <= (next_state == ST_RETRACT);
         motor_extend  <= (next_state == ST_EXTEND);
         if (alarm_set)      alarm <= 1'b1;
         else if (alarm_clr) alarm <= 1'b0;
      end
   end

   assign fault     = (state == ST_FAULT);
   assign state_led = state;

endmodule

// File: tb/tb_vault_door_actuator.sv
// Directed bench for vault_door_actuator with a 1 ms tick equal to one clock.
module tb_vault_door_actuator;
   import vault_pkg::*;

   logic       clk = 1'b0;
   logic       rst, unlock, bolt_in, bolt_out, door_closed, ack_fault;
   logic       motor_retract, motor_extend, alarm, fault;
   logic [2:0] state_led;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   vault_door_actuator #(
      .CLK_HZ          (1000),
      .DEBOUNCE_MS     (2),
      .BOLT_TIMEOUT_MS (10),
      .RELOCK_MS       (20),
      .AJAR_MS         (30)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .unlock        (unlock),
      .bolt_in       (bolt_in),
      .bolt_out      (bolt_out),
      .door_closed   (door_closed),
      .ack_fault     (ack_fault),
      .motor_retract (motor_retract),
      .motor_extend  (motor_extend),
      .alarm         (alarm),
      .fault         (fault),
      .state_led     (state_led)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns cycles until state_led equals s, or -1 if the bound expires.
   task automatic wait_state(input logic [2:0] s, input int max, output int n);
      n = -1;
      for (int i = 1; i <= max && n < 0; i++) begin
         step(1);
         if (state_led === s) n = i;
      end
   endtask

   task automatic pulse_ack();
      ack_fault = 1'b1;
      step(4);
      ack_fault = 1'b0;
      step(3);
   endtask

   task automatic test_reset();
      rst = 1'b1; unlock = 1'b0; bolt_in = 1'b0; bolt_out = 1'b1;
      door_closed = 1'b1; ack_fault = 1'b0;
      step(3);
      rst = 1'b0;
      step(2);
      checks++; if (state_led !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_led); end
      checks++; if (motor_retract !== 1'b0 || motor_extend !== 1'b0) begin errors++; $display("FAIL reset_motors: got %b%b expected 00", motor_retract, motor_extend); end
      checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
   endtask

   task automatic test_glitch();
      logic seen = 1'b0;
      door_closed = 1'b0;
      step(1);
      door_closed = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (alarm !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_alarm: got 1 expected 0"); end
      checks++; if (state_led !== ST_LOCKED) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", state_led, ST_LOCKED); end
   endtask

   task automatic test_forced_entry();
      door_closed = 1'b0;
      step(3);
      door_closed = 1'b1;
      step(1);
      unlock = 1'b1;
      step(1);
      checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL forced_alarm: got %b expected 1", alarm); end
      checks++; if (state_led !== ST_LOCKED) begin errors++; $display("FAIL forced_state: got %0d expected %0d", state_led, ST_LOCKED); end
      step(1);
      checks++; if (state_led !== ST_LOCKED || motor_retract !== 1'b0) begin errors++; $display("FAIL forced_no_retract: got state %0d motor %b expected 0 0", state_led, motor_retract); end
      unlock = 1'b0;
      step(4);
      pulse_ack();
      checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL forced_alarm_clear: got %b expected 0", alarm); end
   endtask

   task automatic test_normal_cycle();
      int n;
      unlock = 1'b1;
      step(1);
      checks++; if (state_led !== ST_RETRACT || motor_retract !== 1'b1 || motor_extend !== 1'b0) begin errors++; $display("FAIL normal_retract: got state %0d motors %b%b expected 1 10", state_led, motor_retract, motor_extend); end
      bolt_out = 1'b0;
      step(3);
      bolt_in = 1'b1;
      wait_state(ST_UNLOCKED, 6, n);
      checks++; if (n !== 3) begin errors++; $display("FAIL normal_unlocked_latency: got %0d expected 3", n); end
      checks++; if (motor_retract !== 1'b0) begin errors++; $display("FAIL normal_unlocked_motor: got %b expected 0", motor_retract); end
      door_closed = 1'b0;
      step(3);
      door_closed = 1'b1;
      wait_state(ST_DOOR_OPEN, 6, n);
      checks++; if (n < 0) begin errors++; $display("FAIL normal_door_open: got state %0d expected %0d", state_led, ST_DOOR_OPEN); end
      unlock = 1'b0;
      wait_state(ST_EXTEND, 10, n);
      checks++; if (n < 0 || motor_extend !== 1'b1 || motor_retract !== 1'b0) begin errors++; $display("FAIL normal_extend: got state %0d motors %b%b expected 4 01", state_led, motor_retract, motor_extend); end
      bolt_in = 1'b0;
      bolt_out = 1'b1;
      wait_state(ST_LOCKED, 6, n);
      checks++; if (n !== 3) begin errors++; $display("FAIL normal_locked_latency: got %0d expected 3", n); end
      checks++; if (alarm !== 1'b0 || motor_extend !== 1'b0) begin errors++; $display("FAIL normal_locked_outputs: got alarm %b motor %b expected 0 0", alarm, motor_extend); end
   endtask

   task automatic test_relock();
      int n;
      unlock = 1'b1;
      step(1);
      bolt_out = 1'b0;
      bolt_in = 1'b1;
      wait_state(ST_UNLOCKED, 6, n);
      checks++; if (n < 0) begin errors++; $display("FAIL relock_unlocked: got state %0d expected %0d", state_led, ST_UNLOCKED); end
      wait_state(ST_EXTEND, 30, n);
      checks++; if (n !== 20) begin errors++; $display("FAIL relock_ticks: got %0d expected 20", n); end
      unlock = 1'b0;
      bolt_in = 1'b0;
      bolt_out = 1'b1;
      wait_state(ST_LOCKED, 6, n);
      checks++; if (n < 0) begin errors++; $display("FAIL relock_locked: got state %0d expected %0d", state_led, ST_LOCKED); end
   endtask

   task automatic test_jam();
      int n;
      unlock = 1'b1;
      step(1);
      bolt_out = 1'b0;
      wait_state(ST_FAULT, 15, n);
      checks++; if (n !== 10) begin errors++; $display("FAIL jam_timeout: got %0d expected 10", n); end
      checks++; if (motor_retract !== 1'b0 || motor_extend !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL jam_outputs: got motors %b%b fault %b expected 00 1", motor_retract, motor_extend, fault); end
      unlock = 1'b0;
      pulse_ack();
      checks++; if (state_led !== ST_EXTEND || fault !== 1'b0 || motor_extend !== 1'b1) begin errors++; $display("FAIL jam_ack_extend: got state %0d fault %b motor %b expected 4 0 1", state_led, fault, motor_extend); end
      bolt_out = 1'b1;
      wait_state(ST_LOCKED, 6, n);
      checks++; if (n < 0) begin errors++; $display("FAIL jam_relocked: got state %0d expected %0d", state_led, ST_LOCKED); end
   endtask

   task automatic test_both_limits();
      int n;
      unlock = 1'b1;
      step(1);
      bolt_out = 1'b0;
      bolt_in = 1'b1;
      wait_state(ST_UNLOCKED, 6, n);
      bolt_out = 1'b1;
      step(2);
      checks++; if (state_led !== ST_UNLOCKED) begin errors++; $display("FAIL both_limits_early: got %0d expected %0d", state_led, ST_UNLOCKED); end
      step(1);
      checks++; if (state_led !== ST_FAULT || fault !== 1'b1) begin errors++; $display("FAIL both_limits_fault: got state %0d fault %b expected 5 1", state_led, fault); end
      unlock = 1'b0;
      bolt_in = 1'b0;
      step(3);
      pulse_ack();
      checks++; if (state_led !== ST_LOCKED) begin errors++; $display("FAIL both_limits_ack_locked: got %0d expected %0d", state_led, ST_LOCKED); end
   endtask

   task automatic test_ajar();
      int n;
      unlock = 1'b1;
      step(1);
      bolt_out = 1'b0;
      bolt_in = 1'b1;
      wait_state(ST_UNLOCKED, 6, n);
      door_closed = 1'b0;
      wait_state(ST_DOOR_OPEN, 8, n);
      unlock = 1'b0;
      step(35);
      checks++; if (state_led !== ST_DOOR_OPEN) begin errors++; $display("FAIL ajar_state: got %0d expected %0d", state_led, ST_DOOR_OPEN); end
`ifdef VAULT_DOOR_AJAR_ALARM_EN
      checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL ajar_alarm: got %b expected 1", alarm); end
`else
      checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL ajar_alarm: got %b expected 0", alarm); end
`endif
      door_closed = 1'b1;
      wait_state(ST_EXTEND, 10, n);
      bolt_in = 1'b0;
      bolt_out = 1'b1;
      wait_state(ST_LOCKED, 6, n);
      checks++; if (n < 0) begin errors++; $display("FAIL ajar_relocked: got state %0d expected %0d", state_led, ST_LOCKED); end
      pulse_ack();
      checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL ajar_alarm_clear: got %b expected 0", alarm); end
   endtask

   task automatic test_reset_mid_retract();
      unlock = 1'b1;
      step(1);
      checks++; if (motor_retract !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b expected 1", motor_retract); end
      bolt_out = 1'b0;
      step(2);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (motor_retract !== 1'b0) begin errors++; $display("FAIL midrst_motor: got %b expected 0", motor_retract); end
      checks++; if (state_led !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", state_led); end
      unlock = 1'b0;
      bolt_out = 1'b1;
      step(2);
      rst = 1'b0;
      step(3);
      checks++; if (state_led !== ST_LOCKED || motor_retract !== 1'b0) begin errors++; $display("FAIL midrst_after: got state %0d motor %b expected 0 0", state_led, motor_retract); end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_forced_entry();
      test_normal_cycle();
      test_relock();
      test_jam();
      test_both_limits();
      test_ajar();
      test_reset_mid_retract();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
